// File: rtl/multicycle_alu.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Logic, arithmetic and compares finish in one cycle; shifts iterate one bit per cycle.
module multicycle_alu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_ALUCtrl,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_OR   = 4'b0010,
        OP_AND  = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRA  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SLT  = 4'b1101,
        OP_SLTU = 4'b1110
    } op_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      op;
    logic [SHW-1:0]  count;
    logic [SHW-1:0]  amount;
    logic            accept;
    logic            is_shift;
    logic [XLEN-1:0] alu_value;
    logic [XLEN-1:0] shifted;

    assign amount   = i_b[SHW-1:0];
    assign accept   = i_valid && o_ready;
    assign is_shift = (i_ALUCtrl == OP_SRA) || (i_ALUCtrl == OP_SRL) || (i_ALUCtrl == OP_SLL);
    assign o_zero   = (o_result == '0);

    always_comb begin
        alu_value = '0;
        case (i_ALUCtrl)
            OP_ADD:  alu_value = i_a + i_b;
            OP_SUB:  alu_value = i_a - i_b;
            OP_OR:   alu_value = i_a | i_b;
            OP_AND:  alu_value = i_a & i_b;
            OP_XOR:  alu_value = i_a ^ i_b;
            OP_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: alu_value = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            default: alu_value = '0;
        endcase
    end

    // One-bit step in the direction of the latched shift op
    always_comb begin
        shifted = o_result;
        case (op)
            OP_SRA:  shifted = {o_result[XLEN-1], o_result[XLEN-1:1]};
            OP_SRL:  shifted = {1'b0, o_result[XLEN-1:1]};
            OP_SLL:  shifted = {o_result[XLEN-2:0], 1'b0};
            default: shifted = o_result;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (is_shift && (amount != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count == SHW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op       <= '0;
            count    <= '0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op       <= i_ALUCtrl;
                        count    <= amount;
                        o_result <= is_shift ? i_a : alu_value;
                    end
                end
                SHIFT: begin
                    o_result <= shifted;
                    count    <= count - SHW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expected result and latency are queued
// when a request is driven and compared when the unit presents its result.
module tb_multicycle_alu;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_ALUCtrl;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_alu #(.XLEN(32)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_ALUCtrl (i_ALUCtrl),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_zero    (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output int lat);
        logic [4:0] amt;
        amt = b[4:0];
        lat = 1;
        case (code)
            4'b0000: res = a + b;
            4'b0001: res = a - b;
            4'b0010: res = a | b;
            4'b0011: res = a & b;
            4'b0100: res = a ^ b;
            4'b0101: begin res = $signed(a) >>> amt; lat = int'(amt) + 1; end
            4'b0110: begin res = a >> amt;           lat = int'(amt) + 1; end
            4'b0111: begin res = a << amt;           lat = int'(amt) + 1; end
            4'b1101: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1110: res = (a < b) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
    endfunction

    // Drive a request, queue its expectation, and wait for the accept edge
    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        model(code, a, b, e.res, e.lat);
        sb.push_back(e);
        i_ALUCtrl = code;
        i_a       = a;
        i_b       = b;
        i_valid   = 1'b1;
        check("ready_before_accept", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic collect(input bit scramble);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!o_valid && cycles < 100) begin
            if (scramble) begin
                i_a       = $urandom;
                i_b       = $urandom;
                i_ALUCtrl = 4'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
        end
        check("valid_timeout", 32'(o_valid), 32'd1);
        e = sb.pop_front();
        check("latency", 32'(cycles + 1), 32'(e.lat));
        check("result", o_result, e.res);
        check("zero", 32'(o_zero), (e.res == 32'd0) ? 32'd1 : 32'd0);
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("valid_after_hs", 32'(o_valid), 32'd0);
        check("ready_after_hs", 32'(o_ready), 32'd1);
    endtask

    task automatic run(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input bit scramble);
        issue(code, a, b);
        collect(scramble);
        handshake();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] codes [12];
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_ALUCtrl = '0;
        i_a       = '0;
        i_b       = '0;
        #13;
        check("rst_ready",  32'(o_ready), 32'd1);
        check("rst_valid",  32'(o_valid), 32'd0);
        check("rst_result", o_result,     32'd0);
        check("rst_zero",   32'(o_zero),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run(4'b0001, 32'd5,         32'd5,         1'b0);
        run(4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run(4'b1110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run(4'b1000, 32'd5,         32'd3,         1'b0);
        run(4'b0010, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0);
        run(4'b0011, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        run(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0);
        run(4'b0101, 32'h8000_0000, 32'h0000_001F, 1'b0);
        run(4'b0110, 32'h8000_0000, 32'h0000_001F, 1'b0);
        run(4'b0111, 32'h0000_0001, 32'h0000_0023, 1'b0);
        run(4'b0111, 32'h1234_5678, 32'h0000_0020, 1'b0);
        run(4'b0101, 32'h9ABC_DEF0, 32'h0000_0007, 1'b1);

        // Result held under backpressure; a pending request waits for IDLE
        issue(4'b0000, 32'd3, 32'd4);
        collect(1'b0);
        i_ALUCtrl = 4'b0001;
        i_a       = 32'd9;
        i_b       = 32'd2;
        i_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid",  32'(o_valid), 32'd1);
            check("hold_result", o_result,     32'd7);
            check("hold_ready",  32'(o_ready), 32'd0);
        end
        handshake();
        issue(4'b0001, 32'd9, 32'd2);
        collect(1'b0);
        handshake();

        // Asynchronous reset in the middle of a 20-step shift
        issue(4'b0110, 32'hF000_0000, 32'd20);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid",  32'(o_valid), 32'd0);
        check("abort_result", o_result,     32'd0);
        check("abort_ready",  32'(o_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(4'b0000, 32'd100, 32'd23, 1'b0);

        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                  4'b0110, 4'b0111, 4'b1101, 4'b1110, 4'b1111, 4'b1010};
        for (int i = 0; i < 24; i++) begin
            run(codes[$urandom_range(11, 0)], $urandom, $urandom, 1'(i % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
